pulse_sched_arbiter: RTL



---
 rtl/pulse_sched_pkg.sv | 36 +++
 rtl/pulse_sched_arbiter_timer.sv | 38 +++
 rtl/pulse_sched_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for the pulse scheduling arbiter: FSM encoding,
// default pulse length and the round-robin winner search.
package pulse_sched_pkg;

    localparam int MAX_REQ          = 8;
    localparam int DEFAULT_LEN_PKG  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of req searching upward from ptr, wrapping at n.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0] ptr,
                                         input int n);
        rr_pick_t r;
        int k;
        r = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            k = (int'(ptr) + i) % n;
            if (i < n && !r.valid && req[k[2:0]]) begin
                r.valid = 1'b1;
                r.idx   = k[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pulse_sched_arbiter_timer.sv
// Shared pulse timer: on load it raises dout for exactly len cycles;
// done flags the final high cycle.
module pulse_timer_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             dout,
    output logic             done
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;

    // Stopping at len-1 keeps the counter from wrapping even at the maximum length.
    assign done = dout && (cnt == len_q - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            len_q <= '0;
            dout  <= 1'b0;
        end else if (load) begin
            cnt   <= '0;
            len_q <= len;
            dout  <= 1'b1;
        end else if (dout) begin
            if (done) begin
                dout <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pulse_sched_arbiter.sv
// Round-robin arbiter sharing one pulse timer among N_REQ requesters.
// Handshake: req is a level; gnt stays high for the whole pulse, ack pulses one cycle after it.
module pulse_sched_arbiter
    import pulse_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_LEN = DEFAULT_LEN_PKG
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   len_i,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    output logic                     dout,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic [1:0]               state_dbg
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] owner_q, owner_nxt;
    logic [IDX_W-1:0] ptr_q, ptr_nxt;
    rr_pick_t         pick;
    logic [IDX_W-1:0] win;
    logic [CNT_W-1:0] sel_len;
    logic [CNT_W-1:0] load_len;
    logic [N_REQ-1:0] owner_oh;
    logic             load;
    logic             tmr_done;

    always_comb begin
        pick     = rr_pick(MAX_REQ'(req), 3'(ptr_q), N_REQ);
        win      = IDX_W'(pick.idx);
        sel_len  = len_i[win*CNT_W +: CNT_W];
        load_len = (sel_len == '0) ? CNT_W'(DEFAULT_LEN) : sel_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state   <= state_nxt;
            owner_q <= owner_nxt;
            ptr_q   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner_q;
        ptr_nxt   = ptr_q;
        case (state)
            IDLE: begin
                if (pick.valid) begin
                    state_nxt = PULSE;
                    owner_nxt = win;
                    ptr_nxt   = (int'(win) == N_REQ-1) ? '0 : win + IDX_W'(1);
                end
            end
            PULSE:   if (tmr_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // gnt and ack are decoded from disjoint states, so they can never overlap.
    always_comb begin
        owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
        load      = (state == IDLE) && pick.valid;
        gnt       = (state == PULSE) ? owner_oh : '0;
        ack       = (state == DONE)  ? owner_oh : '0;
        busy      = (state != IDLE);
        owner     = owner_q;
        state_dbg = state;
    end

    pulse_timer_core #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .len   (load_len),
        .dout  (dout),
        .done  (tmr_done)
    );

endmodule
